// File: rtl/mem_write_checker_if.sv
// Store-bus interface for mem_write_checker.
// Carries the strobe, address and data of the store stream under observation.
//   master : the store source drives mem_write / mem_addr / mem_wdata
//   slave  : the checker observes the same three signals
interface mem_write_checker_if #(
  parameter int ADDR_W = 32,
  parameter int DATA_W = 32
) ();
  logic              mem_write;
  logic [ADDR_W-1:0] mem_addr;
  logic [DATA_W-1:0] mem_wdata;

  modport master (output mem_write, mem_addr, mem_wdata);
  modport slave  (input  mem_write, mem_addr, mem_wdata);
endinterface

// File: rtl/mem_write_checker.sv
// mem_write_checker
// Checks a stream of stores against a preloaded table of expected
// {address, data} pairs, either in table order or in any order, with one
// reserved address filtered out and a cycle budget that bounds each run.
//
// Ports:
//   clk, reset        rising-edge clock, asynchronous active-high reset
//   load_en/idx/addr/data  table write port, honoured only while idle
//   exp_count         number of table entries to check, latched on start
//   start             arms the checker from IDLE, PASS or FAIL
//   mem (slave)       observed store bus: mem_write, mem_addr, mem_wdata
//   busy              run in progress
//   pass / fail       sticky verdicts, never both high
//   fail_code         0 none, 1 mismatch, 2 timeout, 3 bad exp_count
//   fail_addr/data    offending store on a mismatch, otherwise 0
//   match_count       expected writes matched in the current run
module mem_write_checker #(
  parameter int          DATA_W      = 32,
  parameter int          ADDR_W      = 32,
  parameter int          DEPTH       = 8,
  parameter int          ORDERED     = 1,
  parameter int unsigned IGNORE_ADDR = 96,
  parameter int          IGNORE_EN   = 1,
  parameter int          TIMEOUT     = 1024
) (
  input  logic                       clk,
  input  logic                       reset,
  input  logic                       load_en,
  input  logic [$clog2(DEPTH)-1:0]   load_idx,
  input  logic [ADDR_W-1:0]          load_addr,
  input  logic [DATA_W-1:0]          load_data,
  input  logic [$clog2(DEPTH):0]     exp_count,
  input  logic                       start,
  mem_write_checker_if.slave         mem,
  output logic                       busy,
  output logic                       pass,
  output logic                       fail,
  output logic [1:0]                 fail_code,
  output logic [ADDR_W-1:0]          fail_addr,
  output logic [DATA_W-1:0]          fail_data,
  output logic [$clog2(DEPTH):0]     match_count
);

  localparam int IDX_W = $clog2(DEPTH);
  localparam int CNT_W = IDX_W + 1;
  localparam int TO_W  = $clog2(TIMEOUT + 1);

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_RUN  = 2'd1,
    ST_PASS = 2'd2,
    ST_FAIL = 2'd3
  } state_t;

  state_t             state_reg, state_next;
  logic [CNT_W-1:0]   match_reg, match_next;
  logic [CNT_W-1:0]   exp_reg, exp_next;
  logic [TO_W-1:0]    tcnt_reg, tcnt_next;
  logic [DEPTH-1:0]   matched_reg, matched_next;
  logic [1:0]         code_reg, code_next;
  logic [ADDR_W-1:0]  faddr_reg, faddr_next;
  logic [DATA_W-1:0]  fdata_reg, fdata_next;

  // Expected-write table; deliberately not reset, it is reloaded before use.
  logic [ADDR_W-1:0]  tbl_addr [DEPTH];
  logic [DATA_W-1:0]  tbl_data [DEPTH];

  always_ff @(posedge clk) begin
    if (load_en && state_reg == ST_IDLE) begin
      tbl_addr[load_idx] <= load_addr;
      tbl_data[load_idx] <= load_data;
    end
  end

  // Per-entry compare against the current store, and the window of entries
  // that belong to this run.
  logic [DEPTH-1:0] entry_eq;
  logic [DEPTH-1:0] in_window;
  logic [DEPTH-1:0] cand;

  for (genvar gi = 0; gi < DEPTH; gi++) begin : g_entry
    assign entry_eq[gi]  = (tbl_addr[gi] == mem.mem_addr) &&
                           (tbl_data[gi] == mem.mem_wdata);
    assign in_window[gi] = (CNT_W'(gi) < exp_reg);
  end

  assign cand = entry_eq & in_window & ~matched_reg;

  // Lowest-index unmatched candidate: scan downwards so the lowest hit wins.
  logic             unord_hit;
  logic [IDX_W-1:0] unord_sel;

  always_comb begin
    unord_hit = 1'b0;
    unord_sel = '0;
    for (int i = DEPTH - 1; i >= 0; i--) begin
      if (cand[i]) begin
        unord_hit = 1'b1;
        unord_sel = IDX_W'(i);
      end
    end
  end

  // In a run match_count is always below exp_count <= DEPTH, so its low bits
  // index the next in-order entry directly.
  logic [IDX_W-1:0] ord_idx;
  logic             hit;
  logic [IDX_W-1:0] sel;
  logic             ignored;
  logic [CNT_W-1:0] match_inc;
  logic [TO_W-1:0]  tcnt_inc;

  assign ord_idx   = match_reg[IDX_W-1:0];
  assign ignored   = (IGNORE_EN != 0) && (mem.mem_addr == ADDR_W'(IGNORE_ADDR));
  assign match_inc = match_reg + CNT_W'(1);
  assign tcnt_inc  = tcnt_reg + TO_W'(1);

  always_comb begin
    if (ORDERED != 0) begin
      hit = entry_eq[ord_idx];
      sel = ord_idx;
    end else begin
      hit = unord_hit;
      sel = unord_sel;
    end
  end

  always_comb begin
    state_next   = state_reg;
    match_next   = match_reg;
    exp_next     = exp_reg;
    tcnt_next    = tcnt_reg;
    matched_next = matched_reg;
    code_next    = code_reg;
    faddr_next   = faddr_reg;
    fdata_next   = fdata_reg;

    case (state_reg)
      ST_IDLE, ST_PASS, ST_FAIL: begin
        if (start) begin
          match_next   = '0;
          tcnt_next    = '0;
          matched_next = '0;
          code_next    = 2'd0;
          faddr_next   = '0;
          fdata_next   = '0;
          exp_next     = exp_count;
          if (exp_count == '0 || exp_count > CNT_W'(DEPTH)) begin
            state_next = ST_FAIL;
            code_next  = 2'd3;
          end else begin
            state_next = ST_RUN;
          end
        end
      end

      ST_RUN: begin
        tcnt_next = tcnt_inc;
        if (mem.mem_write && !ignored) begin
          if (hit) begin
            match_next        = match_inc;
            matched_next[sel] = 1'b1;
            if (match_inc == exp_reg) begin
              state_next = ST_PASS;
            end
          end else begin
            state_next = ST_FAIL;
            code_next  = 2'd1;
            faddr_next = mem.mem_addr;
            fdata_next = mem.mem_wdata;
          end
        end
        // A verdict reached this cycle takes precedence over the budget.
        if (state_next == ST_RUN && tcnt_inc == TO_W'(TIMEOUT)) begin
          state_next = ST_FAIL;
          code_next  = 2'd2;
        end
      end

      default: state_next = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_reg   <= ST_IDLE;
      match_reg   <= '0;
      exp_reg     <= '0;
      tcnt_reg    <= '0;
      matched_reg <= '0;
      code_reg    <= 2'd0;
      faddr_reg   <= '0;
      fdata_reg   <= '0;
    end else begin
      state_reg   <= state_next;
      match_reg   <= match_next;
      exp_reg     <= exp_next;
      tcnt_reg    <= tcnt_next;
      matched_reg <= matched_next;
      code_reg    <= code_next;
      faddr_reg   <= faddr_next;
      fdata_reg   <= fdata_next;
    end
  end

  assign busy        = (state_reg == ST_RUN);
  assign pass        = (state_reg == ST_PASS);
  assign fail        = (state_reg == ST_FAIL);
  assign fail_code   = code_reg;
  assign fail_addr   = faddr_reg;
  assign fail_data   = fdata_reg;
  assign match_count = match_reg;

endmodule

// File: tb/tb_mem_write_checker.sv
// Testbench for mem_write_checker.
// Two checkers share one stimulus stream: instance 0 is ordered, instance 1
// is unordered, both with a 16-cycle budget. Directed scenarios compare
// against fixed values; the random scenario compares against a queue/array
// reference model of the checking rules.
module tb_mem_write_checker;
  localparam int DW = 16, AW = 16, DEPTH = 8, IW = 3, CW = 4, TO = 16, IGN = 96;
  localparam int M_IDLE = 0, M_RUN = 1, M_PASS = 2, M_FAILED = 3;

  logic          clk = 1'b0;
  logic          reset = 1'b1;
  logic          load_en = 1'b0;
  logic [IW-1:0] load_idx = '0;
  logic [AW-1:0] load_addr = '0;
  logic [DW-1:0] load_data = '0;
  logic [CW-1:0] exp_count = '0;
  logic          start = 1'b0;

  logic          busy_v [2];
  logic          pass_v [2];
  logic          fail_v [2];
  logic [1:0]    code_v [2];
  logic [CW-1:0] mc_v   [2];
  logic [AW-1:0] fa_v   [2];
  logic [DW-1:0] fd_v   [2];

  int checks = 0;
  int passes = 0;

  mem_write_checker_if #(.ADDR_W(AW), .DATA_W(DW)) bus ();

  for (genvar gi = 0; gi < 2; gi++) begin : g_dut
    mem_write_checker #(
      .DATA_W(DW), .ADDR_W(AW), .DEPTH(DEPTH), .ORDERED(gi == 0 ? 1 : 0),
      .IGNORE_ADDR(IGN), .IGNORE_EN(1), .TIMEOUT(TO)
    ) dut (
      .clk(clk), .reset(reset),
      .load_en(load_en), .load_idx(load_idx), .load_addr(load_addr), .load_data(load_data),
      .exp_count(exp_count), .start(start), .mem(bus),
      .busy(busy_v[gi]), .pass(pass_v[gi]), .fail(fail_v[gi]), .fail_code(code_v[gi]),
      .fail_addr(fa_v[gi]), .fail_data(fd_v[gi]), .match_count(mc_v[gi])
    );
  end

  always #5 clk = ~clk;

  // ---------------- reference model ----------------
  logic [AW-1:0] tb_a [DEPTH];
  logic [DW-1:0] tb_d [DEPTH];
  int            m_st [2];
  int            m_cnt [2];
  int            m_exp [2];
  int            m_code [2];
  int            m_cyc [2];
  logic [AW-1:0] m_fa [2];
  logic [DW-1:0] m_fd [2];
  bit            m_used [2][DEPTH];

  function automatic void model_reset();
    for (int u = 0; u < 2; u++) begin
      m_st[u] = M_IDLE; m_cnt[u] = 0; m_exp[u] = 0; m_code[u] = 0; m_cyc[u] = 0;
      m_fa[u] = '0; m_fd[u] = '0;
      for (int i = 0; i < DEPTH; i++) m_used[u][i] = 1'b0;
    end
  endfunction

  function automatic void model_start(int u, int e);
    m_cnt[u] = 0; m_cyc[u] = 0; m_code[u] = 0; m_fa[u] = '0; m_fd[u] = '0; m_exp[u] = e;
    for (int i = 0; i < DEPTH; i++) m_used[u][i] = 1'b0;
    if (e == 0 || e > DEPTH) begin
      m_st[u] = M_FAILED; m_code[u] = 3;
    end else begin
      m_st[u] = M_RUN;
    end
  endfunction

  // One RUN cycle: ordered takes the next entry in sequence, unordered the
  // first unused entry in the window holding the same pair.
  function automatic void model_step(int u, logic w, logic [AW-1:0] a, logic [DW-1:0] d);
    int found;
    m_cyc[u]++;
    if (w && a != AW'(IGN)) begin
      found = -1;
      if (u == 0) begin
        if (tb_a[m_cnt[u]] == a && tb_d[m_cnt[u]] == d) found = m_cnt[u];
      end else begin
        for (int i = 0; i < m_exp[u]; i++)
          if (found < 0 && !m_used[u][i] && tb_a[i] == a && tb_d[i] == d) found = i;
      end
      if (found >= 0) begin
        m_used[u][found] = 1'b1;
        m_cnt[u]++;
        if (m_cnt[u] == m_exp[u]) m_st[u] = M_PASS;
      end else begin
        m_st[u] = M_FAILED; m_code[u] = 1; m_fa[u] = a; m_fd[u] = d;
      end
    end
    if (m_st[u] == M_RUN && m_cyc[u] >= TO) begin
      m_st[u] = M_FAILED; m_code[u] = 2;
    end
  endfunction

  function automatic logic [40:0] mdl_st(int u);
    return {m_st[u] == M_RUN, m_st[u] == M_PASS, m_st[u] == M_FAILED,
            2'(m_code[u]), 4'(m_cnt[u]), m_fa[u], m_fd[u]};
  endfunction

  function automatic logic [40:0] dut_st(int u);
    return {busy_v[u], pass_v[u], fail_v[u], code_v[u], mc_v[u], fa_v[u], fd_v[u]};
  endfunction

  function automatic logic [40:0] pack(logic b, logic p, logic f, int code, int mc,
                                       int fa, int fd);
    return {b, p, f, 2'(code), 4'(mc), AW'(fa), DW'(fd)};
  endfunction

  // ---------------- stimulus primitives ----------------
  task automatic do_reset();
    reset = 1'b1;
    start = 1'b0; load_en = 1'b0; bus.mem_write = 1'b0;
    @(posedge clk); #1;
    reset = 1'b0;
    model_reset();
  endtask

  task automatic load(input int idx, input logic [AW-1:0] a, input logic [DW-1:0] d);
    load_en = 1'b1; load_idx = IW'(idx); load_addr = a; load_data = d;
    @(posedge clk); #1;
    load_en = 1'b0;
    tb_a[idx] = a; tb_d[idx] = d;
  endtask

  task automatic tick(input logic st, input int e, input logic w,
                      input logic [AW-1:0] a, input logic [DW-1:0] d);
    start = st; exp_count = CW'(e);
    bus.mem_write = w; bus.mem_addr = a; bus.mem_wdata = d;
    @(posedge clk);
    for (int u = 0; u < 2; u++) begin
      if (m_st[u] == M_RUN) model_step(u, w, a, d);
      else if (st) model_start(u, e);
    end
    #1;
    start = 1'b0; bus.mem_write = 1'b0;
  endtask

  // ---------------- scenarios ----------------
  task automatic test_reset();
    logic [40:0] want;
    do_reset();
    want = '0;
    for (int u = 0; u < 2; u++) begin
      checks++;
      if (dut_st(u) !== want) $display("FAIL reset dut%0d got %h want %h", u, dut_st(u), want);
      else passes++;
    end
  endtask

  task automatic test_ordered_pass();
    logic [40:0] want;
    do_reset();
    load(0, 100, 25);
    tick(1, 1, 0, 0, 0);
    tick(0, 0, 1, 96, 7);
    want = pack(1, 0, 0, 0, 0, 0, 0);
    for (int u = 0; u < 2; u++) begin
      checks++;
      if (dut_st(u) !== want) $display("FAIL ignore_store dut%0d got %h want %h", u, dut_st(u), want);
      else passes++;
    end
    tick(0, 0, 1, 100, 25);
    want = pack(0, 1, 0, 0, 1, 0, 0);
    for (int u = 0; u < 2; u++) begin
      checks++;
      if (dut_st(u) !== want) $display("FAIL single_pass dut%0d got %h want %h", u, dut_st(u), want);
      else passes++;
    end
  endtask

  task automatic test_order_modes();
    logic [40:0] want [2];
    do_reset();
    load(0, 80, 1);
    load(1, 84, 2);
    tick(1, 2, 0, 0, 0);
    tick(0, 0, 1, 84, 2);
    want[0] = pack(0, 0, 1, 1, 0, 84, 2);
    want[1] = pack(1, 0, 0, 0, 1, 0, 0);
    for (int u = 0; u < 2; u++) begin
      checks++;
      if (dut_st(u) !== want[u]) $display("FAIL out_of_order dut%0d got %h want %h", u, dut_st(u), want[u]);
      else passes++;
    end
    tick(0, 0, 1, 80, 1);
    want[1] = pack(0, 1, 0, 0, 2, 0, 0);
    for (int u = 0; u < 2; u++) begin
      checks++;
      if (dut_st(u) !== want[u]) $display("FAIL any_order_pass dut%0d got %h want %h", u, dut_st(u), want[u]);
      else passes++;
    end
  endtask

  task automatic test_timeout();
    logic [40:0] want;
    do_reset();
    load(0, 5, 5);
    tick(1, 1, 0, 0, 0);
    for (int i = 1; i <= 15; i++) tick(0, 0, (i == 5), 96, 3);
    want = pack(1, 0, 0, 0, 0, 0, 0);
    for (int u = 0; u < 2; u++) begin
      checks++;
      if (dut_st(u) !== want) $display("FAIL before_timeout dut%0d got %h want %h", u, dut_st(u), want);
      else passes++;
    end
    tick(0, 0, 0, 0, 0);
    want = pack(0, 0, 1, 2, 0, 0, 0);
    for (int u = 0; u < 2; u++) begin
      checks++;
      if (dut_st(u) !== want) $display("FAIL timeout dut%0d got %h want %h", u, dut_st(u), want);
      else passes++;
    end
  endtask

  task automatic test_bad_config_and_reset();
    logic [40:0] want;
    do_reset();
    tick(1, 0, 0, 0, 0);
    want = pack(0, 0, 1, 3, 0, 0, 0);
    for (int u = 0; u < 2; u++) begin
      checks++;
      if (dut_st(u) !== want) $display("FAIL exp_zero dut%0d got %h want %h", u, dut_st(u), want);
      else passes++;
    end
    tick(1, DEPTH + 1, 0, 0, 0);
    for (int u = 0; u < 2; u++) begin
      checks++;
      if (dut_st(u) !== want) $display("FAIL exp_too_big dut%0d got %h want %h", u, dut_st(u), want);
      else passes++;
    end
    do_reset();
    load(0, 7, 7);
    load(1, 8, 8);
    tick(1, 2, 0, 0, 0);
    tick(0, 0, 1, 7, 7);
    // Asynchronous reset between edges must clear everything at once.
    reset = 1'b1;
    #2;
    model_reset();
    want = '0;
    for (int u = 0; u < 2; u++) begin
      checks++;
      if (dut_st(u) !== want) $display("FAIL async_reset dut%0d got %h want %h", u, dut_st(u), want);
      else passes++;
    end
    @(posedge clk); #1;
    reset = 1'b0;
    load(0, 200, 9);
    tick(1, 1, 0, 0, 0);
    tick(0, 0, 1, 200, 9);
    want = pack(0, 1, 0, 0, 1, 0, 0);
    for (int u = 0; u < 2; u++) begin
      checks++;
      if (dut_st(u) !== want) $display("FAIL after_reset dut%0d got %h want %h", u, dut_st(u), want);
      else passes++;
    end
  endtask

  task automatic test_back_to_back();
    logic [40:0] want;
    // Restart from PASS with the retained table; start during RUN is ignored.
    tick(1, 1, 0, 0, 0);
    tick(0, 0, 0, 0, 0);
    tick(1, 0, 0, 0, 0);
    want = pack(1, 0, 0, 0, 0, 0, 0);
    for (int u = 0; u < 2; u++) begin
      checks++;
      if (dut_st(u) !== want) $display("FAIL restart_run dut%0d got %h want %h", u, dut_st(u), want);
      else passes++;
    end
    tick(0, 0, 1, 200, 9);
    want = pack(0, 1, 0, 0, 1, 0, 0);
    for (int u = 0; u < 2; u++) begin
      checks++;
      if (dut_st(u) !== want) $display("FAIL restart_pass dut%0d got %h want %h", u, dut_st(u), want);
      else passes++;
    end
  endtask

  task automatic test_random();
    int e, r, idx;
    logic [AW-1:0] a;
    logic [DW-1:0] d;
    for (int s = 0; s < 40; s++) begin
      do_reset();
      for (int i = 0; i < DEPTH; i++)
        load(i, AW'($urandom_range(80, 83)), DW'($urandom_range(0, 2)));
      r = $urandom_range(0, 9);
      e = (r == 0) ? 0 : (r == 1) ? DEPTH + 1 : $urandom_range(1, DEPTH);
      tick(1, e, 0, 0, 0);
      for (int c = 0; c < 20; c++) begin
        r = $urandom_range(0, 9);
        if (r < 3) begin
          idx = (m_cnt[0] < m_exp[0]) ? m_cnt[0] : 0;
          a = tb_a[idx]; d = tb_d[idx];
        end else if (r < 6) begin
          idx = $urandom_range(0, DEPTH - 1);
          a = tb_a[idx]; d = tb_d[idx];
        end else if (r == 6) begin
          a = AW'(IGN); d = DW'($urandom);
        end else begin
          a = AW'($urandom_range(80, 84)); d = DW'($urandom_range(0, 3));
        end
        tick(($urandom_range(0, 15) == 0), $urandom_range(0, DEPTH), (r < 8), a, d);
        for (int u = 0; u < 2; u++) begin
          checks++;
          if (dut_st(u) !== mdl_st(u))
            $display("FAIL random s%0d c%0d dut%0d got %h want %h", s, c, u, dut_st(u), mdl_st(u));
          else passes++;
        end
      end
    end
  endtask

  initial begin
    bus.mem_write = 1'b0;
    bus.mem_addr  = '0;
    bus.mem_wdata = '0;
    model_reset();
    test_reset();
    test_ordered_pass();
    test_order_modes();
    test_timeout();
    test_bad_config_and_reset();
    test_back_to_back();
    test_random();
    $display("%0d/%0d checks passed", passes, checks);
    $finish;
  end

endmodule

// File: doc/mem_write_checker.md
MEM_WRITE_CHECKER -- requirements
Module: mem_write_checker

Interface
REQ-001 Parameter DATA_W, default 32, width of store data compared.
REQ-002 Parameter ADDR_W, default 32, width of store address compared.
REQ-003 Parameter DEPTH, default 8, number of expected-write table entries (power of two, >=2).
REQ-004 Parameter ORDERED, default 1; 1 = expected writes must occur in table order, 0 = any order.
REQ-005 Parameter IGNORE_ADDR, default 96, store address silently ignored while running.
REQ-006 Parameter IGNORE_EN, default 1, enables IGNORE_ADDR filtering.
REQ-007 Parameter TIMEOUT, default 1024, RUN-cycle budget before timeout failure.
REQ-008 Ports, one per line:
 clk  in  1  single system clock, rising edge.
 reset  in  1  asynchronous, active-high reset.
 load_en  in  1  write table entry (IDLE only).
 load_idx  in  $clog2(DEPTH)  table entry index.
 load_addr  in  ADDR_W  expected store address.
 load_data  in  DATA_W  expected store data.
 exp_count  in  $clog2(DEPTH)+1  number of entries to check, sampled on start.
 start  in  1  arm checker.
 mem_write  in  1  DUT store strobe.
 mem_addr  in  ADDR_W  DUT store address.
 mem_wdata  in  DATA_W  DUT store data.
 busy  out  1  high in RUN.
 pass  out  1  sticky success.
 fail  out  1  sticky failure.
 fail_code  out  2  0 none, 1 mismatch, 2 timeout, 3 bad config.
 fail_addr  out  ADDR_W  offending store address (mismatch only, else 0).
 fail_data  out  DATA_W  offending store data (mismatch only, else 0).
 match_count  out  $clog2(DEPTH)+1  expected writes matched so far.

Function
REQ-009 States IDLE, RUN, PASS, FAIL; all inputs sampled on rising clk; outputs registered, updating the cycle after the causing edge.
REQ-010 IDLE: load_en writes {load_addr, load_data} to entry load_idx; load_en ignored in all other states.
REQ-011 start in IDLE, PASS or FAIL: clear match_count, timeout counter, matched flags, fail_* ; latch exp_count; go RUN; table contents retained.
REQ-012 start with latched exp_count = 0 or > DEPTH: go FAIL, fail_code=3.
REQ-013 start in RUN ignored.
REQ-014 RUN, mem_write with IGNORE_EN=1 and mem_addr==IGNORE_ADDR: no state, count or timeout effect beyond normal timeout increment.
REQ-015 ORDERED=1: non-ignored write compared against entry[match_count]; exact addr and data match increments match_count; else FAIL, fail_code=1, fail_addr/fail_data captured.
REQ-016 ORDERED=0: write matches lowest-index unmatched entry among first exp_count with equal addr and data; that entry marked matched, match_count increments; no candidate -> FAIL, code 1, capture.
REQ-017 match_count reaching latched exp_count -> PASS in same update.
REQ-018 Timeout counter increments every RUN cycle; reaching TIMEOUT with no terminal event that cycle -> FAIL, fail_code=2.
REQ-019 Same-cycle completing match and timeout: PASS wins; same-cycle mismatch and timeout: fail_code=1.
REQ-020 PASS and FAIL sticky until start or reset; mem_write ignored there; pass and fail never both high.
REQ-021 busy = (state==RUN).

Reset
REQ-022 reset asserted: immediately state IDLE, busy=pass=fail=0, fail_code=0, fail_addr=fail_data=0, match_count=0, counters and matched flags cleared, regardless of state (including mid-RUN).
REQ-023 Table contents are not required to clear on reset; entries SHALL be reloaded before use.

Verification
REQ-024 ORDERED=1, load {100,25}, exp_count=1, start, stores (96,7) then (100,25) -> pass=1 cycle after second store, match_count=1, fail=0.
REQ-025 ORDERED=1, entries {80,1},{84,2}, exp_count=2, stores (84,2) first -> fail=1, fail_code=1, fail_addr=84, fail_data=2.
REQ-026 ORDERED=0, same entries, stores (84,2),(80,1) -> pass=1, match_count=2.
REQ-027 TIMEOUT=16, start, no stores -> fail=1, fail_code=2 on the 16th RUN cycle edge; busy falls same cycle.
REQ-028 start with exp_count=0 -> fail_code=3 next cycle; then reset mid-RUN after valid start -> all outputs 0, state IDLE, subsequent load/start works.
